// File: rtl/ravenoc_pkg.sv
// Shared router types: arbiter state encoding and the default router port count.
package ravenoc_pkg;

    localparam int RouterPorts = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ravenoc_rr_picker.sv
// Combinational round-robin first-one search starting at ptr and wrapping.
module ravenoc_rr_picker #(
    parameter int N = 5,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         vld
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        pos = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % N;
            if (req[pos]) begin
                idx = W'(pos);
                vld = 1'b1;
            end
        end
        if (vld) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/ravenoc_wormhole_arb.sv
// Wormhole output-port arbiter: round-robin on heads, locks the port until the tail.
// Optional watchdog that breaks a stalled lock: define RAVENOC_ARB_WATCHDOG_EN.
module ravenoc_wormhole_arb
    import ravenoc_pkg::*;
#(
    parameter int NPorts        = RouterPorts,
    parameter int TimeoutCycles = 256,
    localparam int SelW         = (NPorts > 1) ? $clog2(NPorts) : 1
) (
    input  logic              clk_noc,
    input  logic              arst_noc,
    input  logic [NPorts-1:0] req_i,
    input  logic [NPorts-1:0] head_i,
    input  logic [NPorts-1:0] tail_i,
    input  logic              out_ready_i,
    output logic [NPorts-1:0] grant_o,
    output logic [SelW-1:0]   sel_o,
    output logic              locked_o,
    output logic              wd_err_o
);

    arb_state_t        state, state_nxt;
    logic [SelW-1:0]   owner, owner_nxt;
    logic [SelW-1:0]   ptr, ptr_nxt;
    logic [NPorts-1:0] pick_gnt;
    logic [SelW-1:0]   pick_idx;
    logic              pick_vld;
    logic              beat, beat_tail;
    logic              wd_fire;

    function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] i);
        return (int'(i) == NPorts - 1) ? SelW'(0) : i + SelW'(1);
    endfunction

    ravenoc_rr_picker #(.N(NPorts), .W(SelW)) u_picker (
        .req (req_i & head_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Grant is masked during reset so the datapath mux never selects a stale port.
    always_comb begin
        grant_o = '0;
        if (!arst_noc) begin
            if (state == IDLE) grant_o = pick_gnt;
            else if (req_i[owner]) grant_o[owner] = 1'b1;
        end
    end

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < NPorts; k++)
            if (grant_o[k]) sel_o = SelW'(k);
    end

    assign beat      = (|grant_o) & out_ready_i;
    assign beat_tail = beat & (|(grant_o & tail_i));
    assign locked_o  = (state == LOCKED);

`ifdef RAVENOC_ARB_WATCHDOG_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] wd_cnt;
    logic            wd_err;

    // Fires on the stalled cycle that brings the count up to TimeoutCycles.
    assign wd_fire = (state == LOCKED) && !beat && (wd_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (state != LOCKED || beat || wd_fire) wd_cnt <= '0;
            else                                   wd_cnt <= wd_cnt + CntW'(1);
            if (wd_fire) wd_err <= 1'b1;
        end
    end

    assign wd_err_o = wd_err;
`else
    assign wd_fire  = 1'b0;
    assign wd_err_o = 1'b0;
`endif

    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (beat && pick_vld) begin
                    if (beat_tail) begin
                        ptr_nxt = wrap_inc(pick_idx);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = pick_idx;
                    end
                end
            end
            LOCKED: begin
                if (beat_tail || wd_fire) begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_inc(owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/ravenoc_wormhole_arb.md
RAVENOC_WORMHOLE_ARB -- requirements
Module: ravenoc_wormhole_arb

Interface
REQ-001 SHALL take parameter NPorts, default 5, number of input requesters (N, S, W, E, local).
REQ-002 SHALL take parameter TimeoutCycles, default 256, watchdog limit in cycles (used only under REQ-031).
REQ-003 SHALL have clk_noc  input  1  NoC clock; one clock, all logic on its rising edge.
REQ-004 SHALL have arst_noc  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have req_i  input  NPorts  per-port flit valid toward this output.
REQ-006 SHALL have head_i  input  NPorts  per-port flit is packet head.
REQ-007 SHALL have tail_i  input  NPorts  per-port flit is packet tail (head and tail may both be set: single-flit packet).
REQ-008 SHALL have out_ready_i  input  1  downstream output port accepts a flit.
REQ-009 SHALL have grant_o  output  NPorts  one-hot (or zero) grant, selects the datapath mux.
REQ-010 SHALL have sel_o  output  $clog2(NPorts)  binary index of the granted port, 0 when no grant.
REQ-011 SHALL have locked_o  output  1  a packet owns the output.
REQ-012 SHALL have wd_err_o  output  1  sticky watchdog error (tied 0 when the watchdog is compiled out).

Function
REQ-013 SHALL implement states IDLE and LOCKED; owner register and round-robin pointer ptr (0..NPorts-1).
REQ-014 SHALL define a beat as grant_o[k] & req_i[k] & out_ready_i in a cycle.
REQ-015 IDLE: SHALL grant, combinationally in the same cycle, the first port k searching from ptr upward with wrap, having req_i[k] & head_i[k]; non-head requests SHALL be ignored.
REQ-016 IDLE, no beat: SHALL remain IDLE, ptr unchanged; grant may move next cycle.
REQ-017 IDLE, beat with tail: SHALL stay IDLE, ptr <= k+1 mod NPorts.
REQ-018 IDLE, beat without tail: SHALL go LOCKED, owner <= k, locked_o high from next cycle.
REQ-019 LOCKED: grant_o SHALL be the owner bit only, gated by req_i[owner]; all other requests (including heads) SHALL be blocked.
REQ-020 LOCKED, owner beat with tail: SHALL return to IDLE, ptr <= owner+1 mod NPorts.
REQ-021 LOCKED: owner bubbles (req_i low) or back-pressure (out_ready_i low) SHALL hold the lock indefinitely (unless REQ-031).
REQ-022 head_i on the owner while LOCKED SHALL be treated as a body flit (no re-arbitration).
REQ-023 grant_o SHALL never contain more than one bit set; sel_o SHALL equal index of grant_o.
REQ-024 Arbitration latency SHALL be zero cycles; releasing a lock SHALL allow a new grant in the next cycle (no idle gap).

Reset
REQ-025 Asserting arst_noc SHALL immediately force IDLE, ptr 0, owner 0, wd counter 0, wd_err_o 0.
REQ-026 grant_o and sel_o SHALL be 0 while arst_noc is high; locked_o 0.
REQ-027 Reset mid-packet SHALL drop the lock; no packet state survives.

Configuration
REQ-028 SHALL compile the watchdog only when macro RAVENOC_ARB_WATCHDOG_EN is defined.
REQ-029 Without it: no counter flops, wd_err_o tied 0, lock held until tail.
REQ-030 With it: counter counts cycles in LOCKED with no owner beat, cleared on any owner beat or on entering LOCKED.
REQ-031 With it: counter reaching TimeoutCycles SHALL force IDLE, ptr <= owner+1, and set wd_err_o, sticky until reset.

Structure
REQ-032 SHALL put the state enum and NPorts default (router port count) in ravenoc_pkg.
REQ-033 SHALL use one sub-module, ravenoc_rr_picker: combinational round-robin first-one search from ptr with wrap.

Verification
REQ-034 Reset: hold arst_noc, drive req_i=5'b11111 heads -> grant_o=0, locked_o=0, wd_err_o=0.
REQ-035 Single-flit round-robin: req_i=head_i=tail_i=5'b10101, out_ready_i=1 -> grants 0,2,4,0 on consecutive cycles.
REQ-036 Wormhole lock: port 1 sends head, 3 body, tail while port 3 requests heads -> port 3 granted only in cycle after port 1 tail; locked_o high for 4 cycles.
REQ-037 Back-pressure: out_ready_i=0 for 10 cycles mid-packet of port 2 -> grant_o stays 5'b00100, ptr unchanged, no other grant.
REQ-038 Non-head ignored: IDLE, req_i[4]=1, head_i[4]=0 -> grant_o=0.
REQ-039 Watchdog (macro defined, TimeoutCycles=8): port 0 head then req_i low 8 cycles -> wd_err_o=1, IDLE, next head of port 1 granted; macro undefined -> lock held, wd_err_o=0.
